// File: rtl/strobe_period_meter.sv
// Measures the interval between single-cycle strobes in qualified (enable=1) ticks.
// Each interval is presented on a registered valid/ready output with saturation and drop flags.
module strobe_period_meter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             strobe_in,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic             period_ovf,
  output logic             period_valid,
  input  logic             out_ready,
  output logic             dropped,
  output logic             armed
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             dropped_q, dropped_d;

  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] result;
  logic             res_ovf;

  always_comb begin
    cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + WIDTH'(1);
    result  = enable ? cnt_inc : cnt_q;
    // An exact count of CntMax is indistinguishable from a clamped one.
    res_ovf = (result == CntMax);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    dropped_d = dropped_q;

    if (clear) begin
      state_d   = StIdle;
      cnt_d     = '0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      dropped_d = 1'b0;
    end else begin
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
      case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (strobe_in) begin
            state_d = StRun;
          end
        end
        default: begin
          if (strobe_in) begin
            cnt_d = '0;
            // A consume in the same cycle frees the slot, so capture without a bubble.
            if (!valid_q || out_ready) begin
              period_d = result;
              ovf_d    = res_ovf;
              valid_d  = 1'b1;
            end else begin
              dropped_d = 1'b1;
            end
          end else if (enable) begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign period       = period_q;
  assign period_ovf   = ovf_q;
  assign period_valid = valid_q;
  assign dropped      = dropped_q;
  assign armed        = (state_q == StRun);

endmodule
